// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state encodings, register index and NOP control word
package pipeline_hazard_controller_pkg;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;
  localparam logic [2:0] R0_IDX = 3'd0;
  localparam int CW_W = 16;
  localparam logic [CW_W-1:0] NOP_CW = '0;
endpackage

// File: rtl/pipeline_hazard_controller_raw_hazard_detect.sv
// raw_hazard_detect: flags a stage-2 source read that matches a pending s3/s4 register write
// Ports: s2 source selects and Rn index in; s3/s4 write enables and destinations in; raw_hit_o out.
module raw_hazard_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  logic       src_r0_s2_i,
  input  logic       src_rn_s2_i,
  input  logic [2:0] rn_s2_i,
  input  logic       wr_en_s3_i,
  input  logic [2:0] wr_addr_s3_i,
  input  logic       wr_en_s4_i,
  input  logic [2:0] wr_addr_s4_i,
  output logic       raw_hit_o
);
  logic hit_s3, hit_s4;
  assign hit_s3 = wr_en_s3_i && ((src_r0_s2_i && wr_addr_s3_i == R0_IDX) || (src_rn_s2_i && wr_addr_s3_i == rn_s2_i));
  assign hit_s4 = wr_en_s4_i && ((src_r0_s2_i && wr_addr_s4_i == R0_IDX) || (src_rn_s2_i && wr_addr_s4_i == rn_s2_i));
  assign raw_hit_o = hit_s3 || hit_s4;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: interlock FSM deciding hold/flush/bubble for the four-stage pipeline
// Ports: s2 source/flag reads, s3/s4 write info, lpc_s3, mem_req_s4/mem_ack in;
// hold_s12, hold_s34, bubble_s3, flush_s12, busy, stall_cnt out.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_r0_s2,
  input  logic             src_rn_s2,
  input  logic [2:0]       rn_s2,
  input  logic             flag_rd_s2,
  input  logic             wr_en_s3,
  input  logic [2:0]       wr_addr_s3,
  input  logic             efl_s3,
  input  logic             lpc_s3,
  input  logic             wr_en_s4,
  input  logic [2:0]       wr_addr_s4,
  input  logic             mem_req_s4,
  input  logic             mem_ack,
  output logic             hold_s12,
  output logic             hold_s34,
  output logic             bubble_s3,
  output logic             flush_s12,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             raw_hit, mem_wait;
  raw_hazard_detect u_raw (
    .src_r0_s2_i (src_r0_s2),
    .src_rn_s2_i (src_rn_s2),
    .rn_s2_i     (rn_s2),
    .wr_en_s3_i  (wr_en_s3),
    .wr_addr_s3_i(wr_addr_s3),
    .wr_en_s4_i  (wr_en_s4),
    .wr_addr_s4_i(wr_addr_s4),
    .raw_hit_o   (raw_hit)
  );
  assign mem_wait = mem_req_s4 && !mem_ack;
  // Outputs are gated by rst so an asserted reset silences them before any edge.
  always_comb begin
    state_d   = ST_RUN;
    fcnt_d    = fcnt_q;
    hold_s12  = 1'b0;
    hold_s34  = 1'b0;
    bubble_s3 = 1'b0;
    flush_s12 = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (mem_wait) begin
            hold_s12 = 1'b1;
            hold_s34 = 1'b1;
            state_d  = ST_MEMWAIT;
          end else if (lpc_s3) begin
            flush_s12 = 1'b1;
            bubble_s3 = 1'b1;
            fcnt_d    = 3'(FLUSH_CYC - 1);
            state_d   = FLUSH_CYC > 1 ? ST_FLUSH : ST_RUN;
          end else if (raw_hit || (flag_rd_s2 && efl_s3)) begin
            hold_s12  = 1'b1;
            bubble_s3 = 1'b1;
          end
        end
        ST_FLUSH: begin
          // A memory wait freezes the flush so its remaining cycles are not lost.
          if (mem_wait) begin
            hold_s12 = 1'b1;
            hold_s34 = 1'b1;
            state_d  = ST_FLUSH;
          end else begin
            flush_s12 = 1'b1;
            bubble_s3 = 1'b1;
            fcnt_d    = fcnt_q == 3'd0 ? 3'd0 : fcnt_q - 3'd1;
            state_d   = fcnt_q > 3'd1 ? ST_FLUSH : ST_RUN;
          end
        end
        ST_MEMWAIT: begin
          hold_s12 = 1'b1;
          hold_s34 = 1'b1;
          state_d  = mem_ack ? ST_RUN : ST_MEMWAIT;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end
  assign stall_cnt_d = ((hold_s12 || flush_s12) && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign busy      = state_q != ST_RUN;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Pipeline interlock and sequencing controller for the four-stage RISC pipeline. It sits beside the stage-2/stage-3 control code generators and decides each cycle whether the front end advances, holds, or is flushed. It also decides whether a NOP bubble enters stage 3. It resolves three hazard types:
- register RAW hazards against stages 3 and 4 (no forwarding exists);
- flag hazards from flag-setting instructions in stage 3;
- taken-branch redirects (LPC) and multi-cycle memory waits in stage 4.

## Interface
Parameters:
- FLUSH_CYC, 2: cycles the front end is flushed after a taken branch (1..7).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system-wide clock.
- rst  in  1  asynchronous, active-high reset.
- src_r0_s2  in  1  stage-2 instruction reads R0.
- src_rn_s2  in  1  stage-2 instruction reads Rn.
- rn_s2  in  3  Rn index of the stage-2 instruction (R0 = 3'd0).
- flag_rd_s2  in  1  stage-2 instruction is flag-conditional (JCD/JCA/CCD/CCA/RTC).
- wr_en_s3  in  1  stage-3 instruction will write a register.
- wr_addr_s3  in  3  destination index of the stage-3 instruction.
- efl_s3  in  1  stage-3 instruction updates flags (EFL).
- lpc_s3  in  1  stage 3 loads the PC (taken branch/call/return).
- wr_en_s4  in  1  stage-4 instruction will write a register.
- wr_addr_s4  in  3  destination index of the stage-4 instruction.
- mem_req_s4  in  1  stage 4 is issuing a memory access.
- mem_ack  in  1  memory completes the access this cycle.
- hold_s12  out  1  freeze the PC, opcode buffer and stage-2 registers.
- hold_s34  out  1  freeze the stage-3 and stage-4 registers.
- bubble_s3  out  1  load a NOP control word into stage 3 at the next edge.
- flush_s12  out  1  invalidate the stage-1 and stage-2 contents at the next edge.
- busy  out  1  state is not RUN.
- stall_cnt  out  CNT_W  saturating count of cycles with hold_s12 or flush_s12 = 1.

## Operation
- FSM states: RUN (2'd0), FLUSH (2'd1), MEMWAIT (2'd2). 2'd3 is illegal and recovers to RUN.
- Reset: state RUN, flush counter 0, stall_cnt 0. All outputs are 0.
- RUN applies the first matching rule, in this priority order:
  1. mem_req_s4 and !mem_ack: hold_s12 = 1 and hold_s34 = 1. Next state is MEMWAIT. lpc_s3 is ignored because stage 3 is frozen and re-presents next cycle.
  2. lpc_s3: flush_s12 = 1 and bubble_s3 = 1. The flush counter loads FLUSH_CYC-1. Next state is FLUSH, or stays RUN if FLUSH_CYC = 1.
  3. RAW hazard, i.e. any of the following: hold_s12 = 1 and bubble_s3 = 1.
     - src_r0_s2 and wr_en_s3 and wr_addr_s3 = 0;
     - src_rn_s2 and wr_en_s3 and wr_addr_s3 = rn_s2;
     - the same two tests against s4.
  4. Flag hazard, flag_rd_s2 and efl_s3: hold_s12 = 1 and bubble_s3 = 1.
  5. Otherwise all control outputs are 0.
- FLUSH:
  - Outputs: flush_s12 = 1, bubble_s3 = 1. Hazard inputs are ignored.
  - The counter decrements each cycle; the state returns to RUN in the cycle after the counter reaches 0.
  - mem_req_s4 without ack takes precedence: hold_s34 = 1, hold_s12 = 1, and the counter freezes while the memory wait persists.
- MEMWAIT:
  - Outputs: hold_s12 = 1, hold_s34 = 1; all other control outputs are 0.
  - On mem_ack the outputs are still asserted in that cycle, and the next state is RUN.
- stall_cnt increments on every clk edge where hold_s12 | flush_s12 is 1, and saturates at all-ones.

## Timing
- Control outputs are combinational (Mealy) from state and inputs, valid before the same clk edge. Only the state, flush counter and stall_cnt are registered.
- Branch penalty is FLUSH_CYC cycles: the lpc_s3 cycle plus FLUSH_CYC-1 FLUSH cycles.
- RAW stall lasts until the producer leaves stage 4: two cycles if the producer is in s3, one cycle if it is in s4.
- A memory access acknowledged in the same cycle as its request causes no stall.
- rst asserted mid-FLUSH or mid-MEMWAIT forces RUN and all outputs to 0 immediately, with no synchronous deassert delay on the outputs.

## Structure
- Shared header/package holds:
  - state encodings ST_RUN, ST_FLUSH, ST_MEMWAIT;
  - the R0 index constant;
  - the NOP control word used by bubble_s3 consumers.
- Hazard comparators go in one combinational sub-module, raw_hazard_detect. It takes the s2 sources and the s3/s4 destinations, and produces a raw_hit output.
- The FSM, flush counter and stall counter live in the top module.

## Test plan
- Reset: set rst = 1 in the middle of a FLUSH → all outputs go to 0 immediately and stall_cnt = 0. Release rst → state is RUN.
- RAW hazard: wr_en_s3 = 1, wr_addr_s3 = 3, src_rn_s2 = 1, rn_s2 = 3 → hold_s12 = 1 and bubble_s3 = 1 for 2 cycles as the producer moves to s4, then both 0. stall_cnt = 2.
- Branch: lpc_s3 pulse with FLUSH_CYC = 2 → flush_s12 = 1 in the lpc cycle and the next cycle, then 0. busy = 1 for exactly 1 cycle.
- Memory wait: mem_req_s4 = 1 with mem_ack arriving 3 cycles later → hold_s12 = 1 and hold_s34 = 1 for 4 cycles. A concurrent lpc_s3 is deferred and then produces the flush.
- Flag hazard vs no hazard: flag_rd_s2 with efl_s3 → 1-cycle stall. flag_rd_s2 with efl_s3 = 0 → no stall. stall_cnt saturation is checked with CNT_W = 2.
